// File: rtl/bd_encoder.sv
// Host-to-Braindrop word encoder: maps (leaf code, payload) onto 21-bit BD input words,
// splitting leaf 3 into two flits and counting dropped invalid-leaf words.
module bd_encoder #(
  parameter int unsigned NLEAF     = 5,
  parameter int unsigned BD_WIDTH  = 21,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_dec_v,
  input  logic [4:0]           i_dec_leaf_code,
  input  logic [26:0]          i_dec_payload,
  output logic                 o_dec_a,
  output logic                 o_bd_v,
  output logic [BD_WIDTH-1:0]  o_bd_d,
  input  logic                 i_bd_a,
  output logic                 o_invalid_leaf,
  output logic [CNT_WIDTH-1:0] o_drop_count
);

  localparam logic [4:0] LeafNum   = 5'(NLEAF);
  localparam logic [4:0] LeafSplit = 5'd3;

  typedef enum logic {StAccept, StSecond} state_e;

  state_e               r_state;
  logic                 r_bd_v;
  logic [BD_WIDTH-1:0]  r_bd_d;
  logic [9:0]           r_hold;
  logic                 r_invalid_leaf;
  logic [CNT_WIDTH-1:0] r_drop_count;

  logic                 w_dec_a;
  logic                 w_xfer_in;
  logic                 w_leaf_ok;
  logic [BD_WIDTH-1:0]  w_enc;

  // Ready only in ACCEPT and only if the output register is empty or draining this edge.
  assign w_dec_a   = !i_reset && (r_state == StAccept) && (!r_bd_v || i_bd_a);
  assign w_xfer_in = i_dec_v && w_dec_a;
  assign w_leaf_ok = i_dec_leaf_code < LeafNum;

  always_comb begin
    w_enc = '0;
    case (i_dec_leaf_code)
      5'd0:    w_enc = {2'b00, i_dec_payload[18:0]};
      5'd1:    w_enc = {3'b010, i_dec_payload[17:0]};
      5'd2:    w_enc = {4'b0110, i_dec_payload[16:0]};
      5'd3:    w_enc = {4'b0111, i_dec_payload[16:0]};
      5'd4:    w_enc = {1'b1, i_dec_payload[19:0]};
      default: w_enc = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StAccept;
      r_bd_v         <= 1'b0;
      r_bd_d         <= '0;
      r_hold         <= '0;
      r_invalid_leaf <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      r_invalid_leaf <= 1'b0;
      case (r_state)
        StAccept: begin
          if (w_xfer_in && w_leaf_ok) begin
            r_bd_v <= 1'b1;
            r_bd_d <= w_enc;
            if (i_dec_leaf_code == LeafSplit) begin
              r_hold  <= i_dec_payload[26:17];
              r_state <= StSecond;
            end
          end else begin
            if (w_xfer_in) begin
              r_invalid_leaf <= 1'b1;
              if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
              end
            end
            if (i_bd_a) begin
              r_bd_v <= 1'b0;
            end
          end
        end
        StSecond: begin
          if (i_bd_a) begin
            r_bd_d  <= {4'b0111, 7'b0, r_hold};
            r_state <= StAccept;
          end
        end
        default: r_state <= StAccept;
      endcase
    end
  end

  assign o_dec_a        = w_dec_a;
  assign o_bd_v         = r_bd_v;
  assign o_bd_d         = r_bd_d;
  assign o_invalid_leaf = r_invalid_leaf;
  assign o_drop_count   = r_drop_count;

endmodule

// File: tb/tb_bd_encoder.sv
// Self-checking bench for bd_encoder: directed leaf-map cases plus randomized backpressure
// traffic checked against a table-driven encoding model.
module tb_bd_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_v = 1'b0;
  logic [4:0]  leaf = '0;
  logic [26:0] payload = '0;
  logic        bd_a = 1'b0;
  logic        dec_a, bd_v, inv;
  logic [20:0] bd_d;
  logic [15:0] cnt;
  logic        s_dec_a, s_bd_v, s_inv;
  logic [20:0] s_bd_d;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  logic        a_rand = 1'b0;
  logic        a_fixed = 1'b0;

  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  int          acc_cnt = 0;
  int          inv_cnt = 0;
  int          s_inv_cnt = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_d = '0;

  bd_encoder u_dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_dec_v        (dec_v),
    .i_dec_leaf_code(leaf),
    .i_dec_payload  (payload),
    .o_dec_a        (dec_a),
    .o_bd_v         (bd_v),
    .o_bd_d         (bd_d),
    .i_bd_a         (bd_a),
    .o_invalid_leaf (inv),
    .o_drop_count   (cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  bd_encoder #(.CNT_WIDTH(4)) u_dut_sat (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_dec_v        (dec_v),
    .i_dec_leaf_code(leaf),
    .i_dec_payload  (payload),
    .o_dec_a        (s_dec_a),
    .o_bd_v         (s_bd_v),
    .o_bd_d         (s_bd_d),
    .i_bd_a         (bd_a),
    .o_invalid_leaf (s_inv),
    .o_drop_count   (s_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    bd_a = a_rand ? ($urandom_range(0, 1) == 1) : a_fixed;
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bd_v || bd_d !== prev_d)) stab_err++;
      prev_stall = bd_v && !bd_a;
      prev_d = bd_d;
      if (bd_v && bd_a) obs_q.push_back(bd_d);
      if (dec_v && dec_a) acc_cnt++;
      if (inv) inv_cnt++;
      if (s_inv) s_inv_cnt++;
    end
  end

  // Reference: word = route placed in the MSBs, payload masked to the remaining width.
  task automatic model_push(input int lf, input logic [26:0] p);
    int unsigned rlen[5] = '{2, 3, 4, 4, 1};
    int unsigned rval[5] = '{0, 2, 6, 7, 1};
    int unsigned cw, w;
    if (lf < 5) begin
      cw = 21 - rlen[lf];
      w = (rval[lf] << cw) | (int'(p) & ((1 << cw) - 1));
      exp_q.push_back(w[20:0]);
      if (lf == 3) begin
        w = (7 << 17) | (int'(p) >> 17);
        exp_q.push_back(w[20:0]);
      end
    end
  endtask

  task automatic idle(input int n);
    dec_v = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Enters and leaves at posedge+1; returns just after the accepting edge.
  task automatic send(input logic [4:0] lf, input logic [26:0] p, input int gap, output int waited);
    idle(gap);
    dec_v = 1'b1;
    leaf = lf;
    payload = p;
    waited = 0;
    forever begin
      @(negedge clk);
      if (dec_a) break;
      waited++;
      if (waited > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout leaf=%0d waited=%0d required accept", lf, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    dec_v = 1'b0;
    model_push(int'(lf), p);
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (obs_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d required=%0d", obs_q.size(), n);
    end
    idle(4);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    dec_v = 1'b1;
    leaf = 5'd0;
    payload = 27'h0012345;
    obs_q.delete();
    exp_q.delete();
    acc_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      checks += 4;
      if (bd_v !== 1'b0) begin failures++; $display("FAIL rst_bd_v got=%b required=0", bd_v); end
      if (dec_a !== 1'b0) begin failures++; $display("FAIL rst_dec_a got=%b required=0", dec_a); end
      if (cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h required=0", cnt); end
      if (bd_d !== 21'h0) begin failures++; $display("FAIL rst_bd_d got=%h required=0", bd_d); end
      @(posedge clk);
      #1;
    end
    checks++;
    if (acc_cnt != 0) begin failures++; $display("FAIL rst_accept got=%0d required=0", acc_cnt); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dec_a !== 1'b1) begin failures++; $display("FAIL rst_release_a got=%b required=1", dec_a); end
    @(posedge clk);
    #1;
    dec_v = 1'b0;
    model_push(0, 27'h0012345);
    a_fixed = 1'b1;
    drain(1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      begin failures++; $display("FAIL rst_first_word n=%0d required=%h", obs_q.size(), exp_q[0]); end
  endtask

  task automatic test_single;
    int w;
    obs_q.delete();
    exp_q.delete();
    send(5'd0, 27'h7FFFFFF, 2, w);
    checks += 2;
    if (bd_v !== 1'b1) begin failures++; $display("FAIL l0_v got=%b required=1", bd_v); end
    if (bd_d !== 21'h07FFFF) begin failures++; $display("FAIL l0_d got=%h required=07ffff", bd_d); end
    idle(2);
    @(negedge clk);
    checks++;
    if (bd_v !== 1'b0) begin failures++; $display("FAIL l4_pre_v got=%b required=0", bd_v); end
    @(posedge clk);
    #1;
    send(5'd4, 27'h00ABCDE, 0, w);
    checks += 3;
    if (w != 0) begin failures++; $display("FAIL l4_wait got=%0d required=0", w); end
    if (bd_v !== 1'b1) begin failures++; $display("FAIL l4_v got=%b required=1", bd_v); end
    if (bd_d !== 21'h1ABCDE) begin failures++; $display("FAIL l4_d got=%h required=1abcde", bd_d); end
    drain(2);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1])
      begin failures++; $display("FAIL single_seq n=%0d required=2", obs_q.size()); end
  endtask

  task automatic test_two_flit;
    int w;
    obs_q.delete();
    exp_q.delete();
    send(5'd3, 27'h5A5A5A5, 1, w);
    checks += 2;
    if (bd_v !== 1'b1) begin failures++; $display("FAIL l3_v1 got=%b required=1", bd_v); end
    if (bd_d !== 21'h0FA5A5) begin failures++; $display("FAIL l3_flit1 got=%h required=0fa5a5", bd_d); end
    dec_v = 1'b1;
    leaf = 5'd0;
    @(negedge clk);
    checks++;
    if (dec_a !== 1'b0) begin failures++; $display("FAIL l3_second_a got=%b required=0", dec_a); end
    @(posedge clk);
    #1;
    dec_v = 1'b0;
    checks += 2;
    if (bd_v !== 1'b1) begin failures++; $display("FAIL l3_v2 got=%b required=1", bd_v); end
    if (bd_d !== 21'h0E02D2) begin failures++; $display("FAIL l3_flit2 got=%h required=0e02d2", bd_d); end
    @(posedge clk);
    #1;
    checks++;
    if (bd_v !== 1'b0) begin failures++; $display("FAIL l3_done_v got=%b required=0", bd_v); end
    drain(2);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1])
      begin failures++; $display("FAIL l3_seq n=%0d required=2", obs_q.size()); end
  endtask

  task automatic test_back_to_back;
    int w;
    logic [4:0] lfs[4] = '{5'd0, 5'd1, 5'd2, 5'd4};
    obs_q.delete();
    exp_q.delete();
    foreach (lfs[i]) begin
      send(lfs[i], 27'($urandom), 0, w);
      checks++;
      if (w != 0) begin failures++; $display("FAIL b2b_wait idx=%0d got=%0d required=0", i, w); end
    end
    drain(4);
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d required=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin failures++; $display("FAIL b2b_word idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_invalid;
    int w;
    int i0, si0;
    obs_q.delete();
    exp_q.delete();
    i0 = inv_cnt;
    checks++;
    if (cnt !== 16'h0) begin failures++; $display("FAIL inv_cnt_start got=%h required=0", cnt); end
    send(5'd1, 27'($urandom), 0, w);
    send(5'd7, 27'($urandom), 0, w);
    send(5'd2, 27'($urandom), 0, w);
    drain(2);
    checks += 5;
    if (obs_q.size() != 2) begin failures++; $display("FAIL inv_words got=%0d required=2", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0] !== exp_q[0])
      begin failures++; $display("FAIL inv_w0 got=%h required=%h", obs_q[0], exp_q[0]); end
    if (obs_q.size() > 1 && obs_q[1] !== exp_q[1])
      begin failures++; $display("FAIL inv_w1 got=%h required=%h", obs_q[1], exp_q[1]); end
    if (inv_cnt - i0 != 1) begin failures++; $display("FAIL inv_pulse got=%0d required=1", inv_cnt - i0); end
    if (cnt !== 16'd1) begin failures++; $display("FAIL inv_cnt got=%h required=1", cnt); end
    obs_q.delete();
    i0 = inv_cnt;
    si0 = s_inv_cnt;
    for (int k = 0; k < 20; k++) send(5'($urandom_range(5, 31)), 27'($urandom), 0, w);
    idle(3);
    checks += 5;
    if (s_cnt !== 4'hF) begin failures++; $display("FAIL sat_cnt got=%h required=f", s_cnt); end
    if (cnt !== 16'd21) begin failures++; $display("FAIL inv_cnt21 got=%0d required=21", cnt); end
    if (s_inv_cnt - si0 != 20) begin failures++; $display("FAIL sat_pulse got=%0d required=20", s_inv_cnt - si0); end
    if (inv_cnt - i0 != 20) begin failures++; $display("FAIL inv_pulse20 got=%0d required=20", inv_cnt - i0); end
    if (obs_q.size() != 0) begin failures++; $display("FAIL inv_no_out got=%0d required=0", obs_q.size()); end
  endtask

  task automatic test_backpressure;
    int w, n;
    obs_q.delete();
    exp_q.delete();
    stab_err = 0;
    a_rand = 1'b1;
    for (int k = 0; k < 1000; k++)
      send(5'($urandom_range(0, 4)), 27'($urandom), $urandom_range(0, 2), w);
    drain(exp_q.size());
    a_rand = 1'b0;
    a_fixed = 1'b1;
    idle(2);
    checks += 2;
    if (obs_q.size() != exp_q.size())
      begin failures++; $display("FAIL bp_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    if (stab_err != 0) begin failures++; $display("FAIL bp_stable got=%0d required=0", stab_err); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin failures++; $display("FAIL bp_word idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int w;
    a_fixed = 1'b0;
    idle(3);
    obs_q.delete();
    exp_q.delete();
    send(5'd3, 27'($urandom), 0, w);
    idle(2);
    @(negedge clk);
    checks += 2;
    if (bd_v !== 1'b1) begin failures++; $display("FAIL mid_stall_v got=%b required=1", bd_v); end
    if (dec_a !== 1'b0) begin failures++; $display("FAIL mid_stall_a got=%b required=0", dec_a); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_fixed = 1'b1;
    idle(5);
    checks += 2;
    if (obs_q.size() != 0) begin failures++; $display("FAIL mid_no_flit got=%0d required=0", obs_q.size()); end
    if (bd_v !== 1'b0) begin failures++; $display("FAIL mid_v got=%b required=0", bd_v); end
    exp_q.delete();
    send(5'd0, 27'($urandom), 0, w);
    drain(1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      begin failures++; $display("FAIL mid_next_word n=%0d required=%h", obs_q.size(), exp_q[0]); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_two_flit();
    test_back_to_back();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
